// File: rtl/fpu_seq_unit.sv
// rtl/fpu_seq_unit.sv - sequential single-precision FADD/FSUB/FMUL/FDIV unit
// Optional divider datapath enabled by defining FPU_SEQ_DIV_EN.
module fpu_seq_unit (
  input  logic        clk,
  input  logic        clk_oe,
  input  logic        rst,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        q,
  output logic [31:0] out,
  output logic        dn,
  output logic        busy
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [2:0]  OP_SUB = 3'd1;
  localparam logic [2:0]  OP_MUL = 3'd2;
  localparam logic [2:0]  OP_DIV = 3'd3;
  localparam logic [31:0] QNAN   = 32'h7FC00000;

  logic [2:0]         state, op_r;
  logic [31:0]        a_r, b_r, spec_val, out_r;
  logic               sa, sb, spec_en, sign_r;
  logic [7:0]         ea, eb;
  logic [23:0]        ma, mb;
  logic [4:0]         cnt;
  logic [47:0]        acc;
  logic signed [10:0] exp_w;
`ifdef FPU_SEQ_DIV_EN
  logic [24:0]        rem;
`endif

  logic multi_cycle;
`ifdef FPU_SEQ_DIV_EN
  assign multi_cycle = (op_r == OP_MUL) || (op_r == OP_DIV);
`else
  assign multi_cycle = (op_r == OP_MUL);
`endif

  // Unpack: denormals flush to zero; special results decided up front
  logic [23:0] u_ma, u_mb;
  logic        u_spec;
  logic [31:0] u_val;
  always_comb begin
    u_ma   = (a_r[30:23] == 8'd0) ? 24'd0 : {1'b1, a_r[22:0]};
    u_mb   = (b_r[30:23] == 8'd0) ? 24'd0 : {1'b1, b_r[22:0]};
    u_spec = 1'b0;
    u_val  = 32'd0;
    if (op_r[2]) begin
      u_spec = 1'b1;
    end else if (a_r[30:23] == 8'hFF || b_r[30:23] == 8'hFF) begin
      u_spec = 1'b1;
      u_val  = QNAN;
    end else if (op_r == OP_DIV) begin
`ifdef FPU_SEQ_DIV_EN
      if (b_r[30:23] == 8'd0) begin
        u_spec = 1'b1;
        u_val  = (a_r[30:23] == 8'd0) ? QNAN : {a_r[31] ^ b_r[31], 8'hFF, 23'd0};
      end
`else
      u_spec = 1'b1;
      u_val  = QNAN;
`endif
    end else if (op_r == OP_MUL && (a_r[30:23] == 8'd0 || b_r[30:23] == 8'd0)) begin
      u_spec = 1'b1;
      u_val  = {a_r[31] ^ b_r[31], 31'd0};
    end
  end

  // Add/sub: two guard bits below the hidden bit, larger magnitude first
  logic        eff_sb, a_big, s_l, s_s;
  logic [7:0]  e_l, e_s, d;
  logic [23:0] m_l, m_s;
  logic [25:0] al_l, al_s;
  logic [26:0] sum;
  always_comb begin
    eff_sb = sb ^ (op_r == OP_SUB);
    a_big  = {ea, ma} >= {eb, mb};
    s_l    = a_big ? sa : eff_sb;
    s_s    = a_big ? eff_sb : sa;
    e_l    = a_big ? ea : eb;
    e_s    = a_big ? eb : ea;
    m_l    = a_big ? ma : mb;
    m_s    = a_big ? mb : ma;
    d      = e_l - e_s;
    al_l   = {m_l, 2'b00};
    al_s   = (d >= 8'd26) ? 26'd0 : ({m_s, 2'b00} >> d);
    sum    = (s_l == s_s) ? ({1'b0, al_l} + {1'b0, al_s})
                          : ({1'b0, al_l} - {1'b0, al_s});
  end

  // exp_w is the exponent the result would have if its leading one sat at bit 23
  logic [5:0]         lz;
  logic signed [10:0] exp_n;
  logic [22:0]        mant_n;
  logic [31:0]        norm_val;
  always_comb begin
    lz = 6'd0;
    for (int i = 0; i < 48; i++) if (acc[i]) lz = 6'(i);
    exp_n  = exp_w + $signed({5'd0, lz}) - 11'sd23;
    mant_n = 23'((lz >= 6'd23) ? (acc >> (lz - 6'd23)) : (acc << (6'd23 - lz)));
    if (acc == 48'd0)           norm_val = {sign_r, 31'd0};
    else if (exp_n > 11'sd254)  norm_val = {sign_r, 8'hFF, 23'd0};
    else if (exp_n < 11'sd1)    norm_val = {sign_r, 31'd0};
    else                        norm_val = {sign_r, exp_n[7:0], mant_n};
  end

  always_ff @(posedge clk) begin
    if (clk_oe) begin
      if (rst) begin
        state <= S_IDLE; op_r <= 3'd0; a_r <= 32'd0; b_r <= 32'd0;
        sa <= 1'b0; sb <= 1'b0; ea <= 8'd0; eb <= 8'd0; ma <= 24'd0; mb <= 24'd0;
        spec_en <= 1'b0; spec_val <= 32'd0; sign_r <= 1'b0; cnt <= 5'd0;
        acc <= 48'd0; exp_w <= 11'sd0; out_r <= 32'd0;
`ifdef FPU_SEQ_DIV_EN
        rem <= 25'd0;
`endif
      end else begin
        case (state)
          S_IDLE: if (q) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            state <= S_UNPACK;
          end
          S_UNPACK: begin
            sa <= a_r[31]; ea <= a_r[30:23]; ma <= u_ma;
            sb <= b_r[31]; eb <= b_r[30:23]; mb <= u_mb;
            spec_en  <= u_spec;
            spec_val <= u_val;
            acc      <= 48'd0;
            cnt      <= 5'd0;
`ifdef FPU_SEQ_DIV_EN
            rem      <= {1'b0, u_ma};
`endif
            state    <= S_EXEC;
          end
          S_EXEC: begin
            cnt <= cnt + 5'd1;
            if (op_r == OP_MUL) begin
              sign_r <= sa ^ sb;
              exp_w  <= $signed({3'd0, ea}) + $signed({3'd0, eb}) - 11'sd150;
              acc    <= acc + (mb[cnt] ? ({24'd0, ma} << cnt) : 48'd0);
`ifdef FPU_SEQ_DIV_EN
            end else if (op_r == OP_DIV) begin
              sign_r <= sa ^ sb;
              exp_w  <= $signed({3'd0, ea}) - $signed({3'd0, eb}) + 11'sd127;
              if (rem >= {1'b0, mb}) begin
                acc <= {acc[46:0], 1'b1};
                rem <= (rem - {1'b0, mb}) << 1;
              end else begin
                acc <= {acc[46:0], 1'b0};
                rem <= rem << 1;
              end
`endif
            end else begin
              sign_r <= (sum == 27'd0) ? 1'b0 : s_l;
              exp_w  <= $signed({3'd0, e_l}) - 11'sd2;
              acc    <= {21'd0, sum};
            end
            if (!multi_cycle || cnt == 5'd23) state <= S_NORM;
          end
          S_NORM: begin
            out_r <= spec_en ? spec_val : norm_val;
            state <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign out  = out_r;
  assign dn   = (state == S_DONE);
  assign busy = (state != S_IDLE);
endmodule
